// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin burst arbiter sharing one fifo_sync write port
//            among NUM_REQ producers, with a running beat counter.
// Revision : 1.0
// ============================================================================
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int IDX_W     = 2,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        i_req_valid,
   input  logic [NUM_REQ-1:0]        i_req_last,
   input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
   output logic [NUM_REQ-1:0]        o_req_ready,
   input  logic                      i_fifo_full,
   output logic                      o_fifo_wr_en,
   output logic [DATA_W-1:0]         o_fifo_data_in,
   output logic                      o_grant_active,
   output logic [IDX_W-1:0]          o_grant_id,
   output logic [CNT_W-1:0]          o_beat_count
);

   localparam int                   c_BURST_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [c_BURST_W-1:0] c_BURST_END = c_BURST_W'(MAX_BURST - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t               r_state;
   logic                 r_grant_active;
   logic [IDX_W-1:0]     r_grant_id;
   logic [IDX_W-1:0]     r_last_grant;
   logic [c_BURST_W-1:0] r_burst_cnt;
   logic [CNT_W-1:0]     r_beat_count;

   logic                 w_pick_valid;
   logic [IDX_W-1:0]     w_pick_idx;
   logic [IDX_W-1:0]     w_cand;
   logic                 w_sel_valid;
   logic                 w_sel_last;
   logic [DATA_W-1:0]    w_sel_data;
   logic                 w_beat;

   // Search starts just after the last granted producer so the previous owner ranks lowest.
   always_comb begin
      w_pick_valid = 1'b0;
      w_pick_idx   = '0;
      w_cand       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = IDX_W'((int'(r_last_grant) + k) % NUM_REQ);
         if (!w_pick_valid && i_req_valid[w_cand]) begin
            w_pick_valid = 1'b1;
            w_pick_idx   = w_cand;
         end
      end
   end

   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_last  = 1'b0;
      w_sel_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grant_id == IDX_W'(i)) begin
            w_sel_valid = i_req_valid[i];
            w_sel_last  = i_req_last[i];
            w_sel_data  = i_req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // A beat landing in a reset cycle is dropped so the FIFO never sees it.
   assign w_beat = (r_state == ST_GRANT) && w_sel_valid && !i_fifo_full && !rst;

   always_comb begin
      o_req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         o_req_ready[i] = w_beat && (r_grant_id == IDX_W'(i));
      end
   end

   assign o_fifo_wr_en   = w_beat;
   assign o_fifo_data_in = (r_state == ST_GRANT) ? w_sel_data : '0;
   assign o_grant_active = r_grant_active;
   assign o_grant_id     = r_grant_id;
   assign o_beat_count   = r_beat_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_grant_active <= 1'b0;
         r_grant_id     <= '0;
         r_last_grant   <= IDX_W'(NUM_REQ - 1);
         r_burst_cnt    <= '0;
         r_beat_count   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pick_valid) begin
                  r_state        <= ST_GRANT;
                  r_grant_active <= 1'b1;
                  r_grant_id     <= w_pick_idx;
                  r_last_grant   <= w_pick_idx;
                  r_burst_cnt    <= '0;
               end
            end
            ST_GRANT: begin
               if (w_beat) begin
                  r_beat_count <= r_beat_count + CNT_W'(1);
                  if (w_sel_last || (r_burst_cnt == c_BURST_END)) begin
                     r_state        <= ST_IDLE;
                     r_grant_active <= 1'b0;
                     r_burst_cnt    <= '0;
                  end else begin
                     r_burst_cnt <= r_burst_cnt + c_BURST_W'(1);
                  end
               end else if (!w_sel_valid) begin
                  r_state        <= ST_IDLE;
                  r_grant_active <= 1'b0;
                  r_burst_cnt    <= '0;
               end
            end
            default: begin
               r_state        <= ST_IDLE;
               r_grant_active <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Directed scoreboard bench for fifo_wr_arbiter (CNT_W=8 for wrap).
// Revision : 1.0
// ============================================================================
module tb_fifo_wr_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int IDX_W     = 2;
   localparam int DATA_W    = 8;
   localparam int MAX_BURST = 4;
   localparam int CNT_W     = 8;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NUM_REQ-1:0]        i_req_valid;
   logic [NUM_REQ-1:0]        i_req_last;
   logic [NUM_REQ*DATA_W-1:0] i_req_data;
   logic [NUM_REQ-1:0]        o_req_ready;
   logic                      i_fifo_full;
   logic                      o_fifo_wr_en;
   logic [DATA_W-1:0]         o_fifo_data_in;
   logic                      o_grant_active;
   logic [IDX_W-1:0]          o_grant_id;
   logic [CNT_W-1:0]          o_beat_count;

   fifo_wr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .IDX_W     (IDX_W),
      .DATA_W    (DATA_W),
      .MAX_BURST (MAX_BURST),
      .CNT_W     (CNT_W)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .i_req_valid    (i_req_valid),
      .i_req_last     (i_req_last),
      .i_req_data     (i_req_data),
      .o_req_ready    (o_req_ready),
      .i_fifo_full    (i_fifo_full),
      .o_fifo_wr_en   (o_fifo_wr_en),
      .o_fifo_data_in (o_fifo_data_in),
      .o_grant_active (o_grant_active),
      .o_grant_id     (o_grant_id),
      .o_beat_count   (o_beat_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Producer models: beats left, burst length (0 = never last), beat in burst, data sequence.
   int p_rem  [NUM_REQ];
   int p_blen [NUM_REQ];
   int p_bcnt [NUM_REQ];
   int p_seq  [NUM_REQ];
   logic tb_rst;
   logic tb_full;

   logic [DATA_W-1:0] exp_q[$];
   int                exp_g[$];
   logic              prev_ga = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] beat_val(input int id, input int seq);
      logic [31:0] id_v;
      logic [31:0] seq_v;
      id_v  = id;
      seq_v = seq;
      return {id_v[1:0], seq_v[5:0]};
   endfunction

   task automatic drive();
      for (int i = 0; i < NUM_REQ; i++) begin
         i_req_valid[i] = (p_rem[i] > 0);
         i_req_last[i]  = (p_blen[i] != 0) && (((p_bcnt[i] + 1) % p_blen[i]) == 0);
         i_req_data[i*DATA_W +: DATA_W] = beat_val(i, p_seq[i]);
      end
      rst         = tb_rst;
      i_fifo_full = tb_full;
   endtask

   // Called at a negedge; returns at the next negedge with new inputs applied.
   task automatic step();
      logic [NUM_REQ-1:0] smp;
      smp = o_req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (smp[i] === 1'b1) begin
            p_seq[i]++;
            p_bcnt[i]++;
            p_rem[i]--;
         end
      end
      drive();
      @(negedge clk);
   endtask

   task automatic setp(input int id, input int rem, input int blen);
      p_rem[id]  = rem;
      p_blen[id] = blen;
      p_bcnt[id] = 0;
   endtask

   task automatic push_beats(input int id, input int off, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(beat_val(id, p_seq[id] + off + k));
   endtask

   task automatic do_reset();
      tb_rst  = 1'b1;
      tb_full = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) setp(i, 0, 0);
      step();
      step();
      tb_rst = 1'b0;
      step();
   endtask

   // Scoreboard side: every FIFO write and every new grant is matched in order.
   always @(negedge clk) begin
      if (o_fifo_wr_en === 1'b1) begin
         chk("wr_while_full", 32'(i_fifo_full), 32'd0);
         n_checks++;
         assert (exp_q.size() > 0) else begin
            n_errors++;
            $error("FAIL sb_underflow: observed write %0h, expected no write", o_fifo_data_in);
         end
         if (exp_q.size() > 0) chk("fifo_data", 32'(o_fifo_data_in), 32'(exp_q.pop_front()));
      end
      if (o_grant_active === 1'b1 && prev_ga === 1'b0) begin
         n_checks++;
         assert (exp_g.size() > 0) else begin
            n_errors++;
            $error("FAIL grant_underflow: observed grant %0d, expected none", o_grant_id);
         end
         if (exp_g.size() > 0) chk("grant_order", 32'(o_grant_id), 32'(exp_g.pop_front()));
      end
      prev_ga = o_grant_active;
   end

   initial begin
      int ga_cycles;
      int wr_cycles;
      tb_rst  = 1'b1;
      tb_full = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         setp(i, 0, 0);
         p_seq[i] = 0;
      end
      drive();

      do_reset();
      chk("rst_grant_active", 32'(o_grant_active), 32'd0);
      chk("rst_grant_id",     32'(o_grant_id),     32'd0);
      chk("rst_beat_count",   32'(o_beat_count),   32'd0);
      chk("rst_wr_en",        32'(o_fifo_wr_en),   32'd0);
      chk("rst_req_ready",    32'(o_req_ready),    32'd0);
      chk("rst_data_in",      32'(o_fifo_data_in), 32'd0);

      // 1: lone producer 0, three-beat burst
      setp(0, 3, 3);
      push_beats(0, 0, 3);
      exp_g.push_back(0);
      step();
      chk("t1_arb_latency_wr_en", 32'(o_fifo_wr_en),   32'd0);
      chk("t1_arb_latency_ga",    32'(o_grant_active), 32'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t1_wr_en",     32'(o_fifo_wr_en), 32'd1);
         chk("t1_grant_id",  32'(o_grant_id),   32'd0);
         chk("t1_req_ready", 32'(o_req_ready),  32'd1);
      end
      step();
      chk("t1_grant_released", 32'(o_grant_active), 32'd0);
      chk("t1_beat_count",     32'(o_beat_count),   32'd3);

      // 2: all four continuously valid, forced rotation every MAX_BURST beats
      do_reset();
      setp(0, 8, 0);
      setp(1, 4, 0);
      setp(2, 4, 0);
      setp(3, 4, 0);
      push_beats(0, 0, 4);
      push_beats(1, 0, 4);
      push_beats(2, 0, 4);
      push_beats(3, 0, 4);
      push_beats(0, 4, 4);
      exp_g.push_back(0);
      exp_g.push_back(1);
      exp_g.push_back(2);
      exp_g.push_back(3);
      exp_g.push_back(0);
      ga_cycles = 0;
      wr_cycles = 0;
      repeat (25) begin
         step();
         ga_cycles += int'(o_grant_active);
         wr_cycles += int'(o_fifo_wr_en);
      end
      chk("t2_grant_cycles", 32'(ga_cycles), 32'd20);
      chk("t2_write_cycles", 32'(wr_cycles), 32'd20);
      step();
      chk("t2_beat_count",   32'(o_beat_count),   32'd20);
      chk("t2_grant_active", 32'(o_grant_active), 32'd0);

      // 3: producer 2 stalled by fifo_full mid-burst
      do_reset();
      setp(2, 4, 4);
      push_beats(2, 0, 4);
      exp_g.push_back(2);
      step();
      step();
      chk("t3_beat0", 32'(o_fifo_wr_en), 32'd1);
      step();
      chk("t3_beat1", 32'(o_fifo_wr_en), 32'd1);
      tb_full = 1'b1;
      repeat (5) begin
         step();
         chk("t3_full_wr_en",     32'(o_fifo_wr_en),   32'd0);
         chk("t3_full_req_ready", 32'(o_req_ready),    32'd0);
         chk("t3_full_grant",     32'(o_grant_active), 32'd1);
         chk("t3_full_grant_id",  32'(o_grant_id),     32'd2);
      end
      tb_full = 1'b0;
      step();
      chk("t3_beat2", 32'(o_fifo_wr_en), 32'd1);
      step();
      chk("t3_beat3", 32'(o_fifo_wr_en), 32'd1);
      step();
      chk("t3_grant_released", 32'(o_grant_active), 32'd0);
      chk("t3_beat_count",     32'(o_beat_count),   32'd4);

      // 4: producer 1 drops valid after one beat; rotation continues to 3 before 0
      do_reset();
      setp(1, 1, 0);
      setp(3, 1, 1);
      push_beats(1, 0, 1);
      push_beats(3, 0, 1);
      push_beats(0, 0, 1);
      exp_g.push_back(1);
      exp_g.push_back(3);
      exp_g.push_back(0);
      step();
      step();
      chk("t4_grant_id1", 32'(o_grant_id),   32'd1);
      chk("t4_wr_en",     32'(o_fifo_wr_en), 32'd1);
      setp(0, 1, 1);
      step();
      chk("t4_drop_no_wr", 32'(o_fifo_wr_en),   32'd0);
      chk("t4_drop_held",  32'(o_grant_active), 32'd1);
      step();
      chk("t4_idle", 32'(o_grant_active), 32'd0);
      step();
      chk("t4_grant_id3", 32'(o_grant_id), 32'd3);
      step();
      step();
      chk("t4_grant_id0", 32'(o_grant_id), 32'd0);
      step();
      chk("t4_beat_count", 32'(o_beat_count), 32'd3);

      // 5: reset lands on beat 2 of a burst
      do_reset();
      setp(0, 4, 0);
      push_beats(0, 0, 2);
      exp_g.push_back(0);
      step();
      step();
      step();
      tb_rst = 1'b1;
      step();
      chk("t5_inflight_wr_en", 32'(o_fifo_wr_en), 32'd0);
      step();
      chk("t5_rst_grant_active", 32'(o_grant_active), 32'd0);
      chk("t5_rst_grant_id",     32'(o_grant_id),     32'd0);
      chk("t5_rst_beat_count",   32'(o_beat_count),   32'd0);
      chk("t5_rst_wr_en",        32'(o_fifo_wr_en),   32'd0);
      tb_rst = 1'b0;
      setp(3, 1, 1);
      push_beats(0, 0, 2);
      push_beats(3, 0, 1);
      exp_g.push_back(0);
      exp_g.push_back(3);
      step();
      step();
      chk("t5_regrant_id", 32'(o_grant_id),     32'd0);
      chk("t5_regrant_ga", 32'(o_grant_active), 32'd1);
      repeat (5) step();
      chk("t5_beat_count", 32'(o_beat_count), 32'd3);

      // 6: 2^CNT_W + 1 single-beat bursts wrap the counter to 1
      do_reset();
      setp(0, 257, 1);
      push_beats(0, 0, 257);
      repeat (257) exp_g.push_back(0);
      repeat (514) step();
      step();
      chk("t6_beat_count_wrap", 32'(o_beat_count),   32'd1);
      chk("t6_grant_active",    32'(o_grant_active), 32'd0);

      chk("sb_drained",     32'(exp_q.size()), 32'd0);
      chk("grants_drained", 32'(exp_g.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
